ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the send direction of the kbd_if receive path. Sends one

---
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 host-to-device transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (output tx_data, tx_start, input busy, done, ack_err, timeout_err);
  modport slave  (input tx_data, tx_start, output busy, done, ack_err, timeout_err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one command
// byte out on device clock falls and checks the device acknowledge, with a device-clock timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2c_in,
  input  logic         ps2d_in,
  output logic         ps2c_oe,
  output logic         ps2d_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE} state_t;

  logic [1:0]       c_sync_reg, d_sync_reg;
  logic             c_sync, d_sync;
  logic             filt_reg, fall_reg;
  logic [FLT_W-1:0] flt_cnt_reg;

  state_t           state_reg;
  logic [8:0]       shift_reg;
  logic [3:0]       bit_cnt_reg;
  logic [INH_W-1:0] inh_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             ps2c_oe_reg, ps2d_oe_reg;
  logic             busy_reg, done_reg, ack_err_reg, timeout_err_reg;
  logic             to_hit, line_idle, abort;

  assign c_sync = c_sync_reg[1];
  assign d_sync = d_sync_reg[1];

  // Synchronizers clear to the released (high) bus level so reset never fakes a clock fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_sync_reg  <= 2'b11;
      d_sync_reg  <= 2'b11;
      filt_reg    <= 1'b1;
      flt_cnt_reg <= '0;
      fall_reg    <= 1'b0;
    end else begin
      c_sync_reg <= {c_sync_reg[0], ps2c_in};
      d_sync_reg <= {d_sync_reg[0], ps2d_in};
      fall_reg   <= 1'b0;
      if (c_sync == filt_reg) begin
        flt_cnt_reg <= '0;
      end else if (flt_cnt_reg == FLT_W'(FILTER_LEN - 1)) begin
        filt_reg    <= c_sync;
        flt_cnt_reg <= '0;
        fall_reg    <= filt_reg;
      end else begin
        flt_cnt_reg <= flt_cnt_reg + 1'b1;
      end
    end
  end

  assign to_hit    = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign line_idle = filt_reg && d_sync;
  // A fall or a completed bus release always wins over a timeout in the same cycle.
  assign abort = to_hit && !fall_reg &&
                 ((state_reg == SEND) || (state_reg == ACK) ||
                  ((state_reg == WAIT_IDLE) && !line_idle));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      inh_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      ps2c_oe_reg     <= 1'b0;
      ps2d_oe_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      ack_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        ps2c_oe_reg     <= 1'b0;
        ps2d_oe_reg     <= 1'b0;
        timeout_err_reg <= 1'b1;
        ack_err_reg     <= 1'b0;
        done_reg        <= 1'b1;
        state_reg       <= DONE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.tx_start && !busy_reg) begin
              shift_reg   <= {~^bus.tx_data, bus.tx_data};
              busy_reg    <= 1'b1;
              ps2c_oe_reg <= 1'b1;
              ps2d_oe_reg <= 1'b0;
              inh_cnt_reg <= '0;
              state_reg   <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
              ps2d_oe_reg <= 1'b1;
              state_reg   <= REQ;
            end else begin
              inh_cnt_reg <= inh_cnt_reg + 1'b1;
            end
          end
          REQ: begin
            ps2c_oe_reg <= 1'b0;
            bit_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            state_reg   <= SEND;
          end
          SEND: begin
            if (fall_reg) begin
              to_cnt_reg  <= '0;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd9) begin
                ps2d_oe_reg <= 1'b0;
                state_reg   <= ACK;
              end else begin
                ps2d_oe_reg <= ~shift_reg[0];
                shift_reg   <= {1'b0, shift_reg[8:1]};
              end
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
            end
          end
          ACK: begin
            if (fall_reg) begin
              ack_err_reg <= d_sync;
              to_cnt_reg  <= '0;
              state_reg   <= WAIT_IDLE;
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (line_idle) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else if (fall_reg) begin
              to_cnt_reg <= '0;
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
            end
          end
          DONE: begin
            busy_reg        <= 1'b0;
            ack_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            state_reg       <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign ps2c_oe         = ps2c_oe_reg;
  assign ps2d_oe         = ps2d_oe_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.ack_err     = ack_err_reg;
  assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model that clocks the frame in.
module tb_ps2_host_tx;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   dev_clk = 1'b1;
  logic   dev_data = 1'b1;
  logic   ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  longint cyc = 0;
  int     done_cnt = 0;
  int     hi_cnt = 0;
  int     chk_cnt = 0;
  int     err_cnt = 0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(1000), .FILTER_LEN(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe)
  );

  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_data & ~ps2d_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (ps2c_oe) hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  // Device model: samples start bit, then each bit just before the rising clock edge; acks on fall 11.
  task automatic dev_frame(input int nf, input bit ack, input bit gl,
                           output logic [10:0] bits, output bit ok, output longint last_fall);
    bits = '0;
    ok = 1'b0;
    last_fall = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ps2c_oe && ps2d_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (20) @(negedge clk);
      bits[0] = ps2d_in;
      for (int n = 1; n <= nf; n++) begin
        dev_clk = 1'b0;
        last_fall = cyc;
        repeat (40) @(negedge clk);
        if (n <= 10) bits[n] = ps2d_in;
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        if (gl && n == 3) begin
          dev_clk = 1'b0;
          @(negedge clk);
          dev_clk = 1'b1;
        end
        if (n == 10 && ack) dev_data = 1'b0;
        repeat (20) @(negedge clk);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int bound, input bit poke, output bit got,
                           output logic ae, output logic te, output longint dcyc);
    got = 1'b0;
    ae = 1'b0;
    te = 1'b0;
    dcyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        ae = bus.ack_err;
        te = bus.timeout_err;
        dcyc = cyc;
        if (poke) begin
          bus.tx_data  = 8'hA5;
          bus.tx_start = 1'b1;
        end
        break;
      end
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input int nf, input bit ack,
                          input bit gl, input logic [10:0] exp_frame, input bit exp_ae,
                          input bit exp_te, input bit second, input bit poke);
    logic [10:0] bits;
    bit          ok, got;
    logic        ae, te;
    longint      lf, dcyc;
    int          hb, dc0;
    hb  = hi_cnt;
    dc0 = done_cnt;
    send_cmd(d);
    check({tag, "_busy_set"}, 32'(bus.busy), 32'd1);
    if (second) begin
      repeat (5) @(negedge clk);
      bus.tx_data  = 8'h55;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
    end
    fork
      dev_frame(nf, ack, gl, bits, ok, lf);
      wait_done(3000, poke, got, ae, te, dcyc);
    join
    check({tag, "_req"}, 32'(ok), 32'd1);
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_ack_err"}, 32'(ae), 32'(exp_ae));
    check({tag, "_timeout_err"}, 32'(te), 32'(exp_te));
    check({tag, "_ps2c_low_cycles"}, 32'(hi_cnt - hb), 32'd21);
    if (exp_te) begin
      check({tag, "_timeout_latency"},
            32'((dcyc - lf >= 1000) && (dcyc - lf <= 1010)), 32'd1);
    end else begin
      check({tag, "_frame"}, 32'(bits), 32'(exp_frame));
    end
    if (poke) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
      @(negedge clk);
      check({tag, "_start_in_done_ignored"}, 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    check({tag, "_ps2c_released"}, 32'(ps2c_oe), 32'd0);
    check({tag, "_ps2d_released"}, 32'(ps2d_oe), 32'd0);
    check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
    check({tag, "_one_done"}, 32'(done_cnt - dc0), 32'd1);
    $display("XFER %s data=%02h frame=%03h ack_err=%0d timeout_err=%0d", tag, d, bits, ae, te);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    bit          ok;
    longint      lf;
    int          dc0;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ack_err", 32'(bus.ack_err), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // frame vectors are {stop, parity, data, start}
    run_xfer("ed",    8'hED, 11, 1'b1, 1'b0, 11'h7DA, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer("x01",   8'h01, 11, 1'b1, 1'b0, 11'h402, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer("xff",   8'hFF, 11, 1'b1, 1'b0, 11'h7FE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer("nack",  8'hED, 11, 1'b0, 1'b0, 11'h7DA, 1'b1, 1'b0, 1'b0, 1'b0);
    run_xfer("tmo",   8'hED,  4, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer("busy",  8'hED, 11, 1'b1, 1'b0, 11'h7DA, 1'b0, 1'b0, 1'b1, 1'b1);
    run_xfer("x55",   8'h55, 11, 1'b1, 1'b0, 11'h6AA, 1'b0, 1'b0, 1'b0, 1'b0);

    dc0 = done_cnt;
    send_cmd(8'h01);
    dev_frame(5, 1'b1, 1'b0, bits, ok, lf);
    check("rst_mid_req", 32'(ok), 32'd1);
    check("rst_mid_ps2d_driven", 32'(ps2d_oe), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_mid_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("rst_mid_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    repeat (50) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - dc0), 32'd0);
    $display("XFER rst_mid data=01 reset during bit 5");

    run_xfer("post_rst", 8'hFF, 11, 1'b1, 1'b0, 11'h7FE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer("glitch",   8'hED, 11, 1'b1, 1'b1, 11'h7DA, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
